// File: rtl/alu_vec_pkg.sv
// Shared definitions for the vector ALU pipeline: opcodes, flag bit
// positions inside each lane's 4-bit flag nibble, and default geometry.
package alu_vec_pkg;

  localparam int DEF_LANES  = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC_W = 8;

  typedef enum logic [2:0] {
    OP_MUL = 3'b000,
    OP_SUB = 3'b001,
    OP_ADD = 3'b010,
    OP_SET = 3'b111
  } op_e;

  // Lane flag nibble layout {N, Z, V, S}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_S = 0;

endpackage

// File: rtl/alu_lane.sv
// One vector lane. The front half forms the exact full-width sum/product
// that the top registers in stage 1; the back half takes that registered
// value, rescales products, saturates or wraps, and derives the lane flags.
module alu_lane
  import alu_vec_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  input  logic [2:0]                 op,
  output logic signed [2*DATA_W-1:0] raw,
  input  logic signed [2*DATA_W-1:0] raw_p1,
  input  logic [2:0]                 op_p1,
  input  logic                       sat_p1,
  input  logic signed [DATA_W-1:0]   c_p1,
  output logic [DATA_W-1:0]          res,
  output logic [3:0]                 flg
);

  localparam int XW = 2 * DATA_W;
  localparam logic signed [XW-1:0] MAX_X = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [XW-1:0] MIN_X = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Returns {V, S, value}: V on any out-of-range value, S only when clamped.
  function automatic logic [DATA_W+1:0] sat_wrap(input logic signed [XW-1:0] x,
                                                 input logic sat);
    logic v;
    logic s;
    logic [DATA_W-1:0] y;
    v = (x > MAX_X) || (x < MIN_X);
    s = v && sat;
    y = x[DATA_W-1:0];
    if (s) y = x[XW-1] ? MIN_X[DATA_W-1:0] : MAX_X[DATA_W-1:0];
    return {v, s, y};
  endfunction

  logic signed [XW-1:0] a_x;
  logic signed [XW-1:0] b_x;
  logic signed [XW-1:0] shf;
  logic [DATA_W+1:0]    sw;
  logic                 v;
  logic                 s;

  // Stage 1 input: exact result at double width, no precision lost yet
  always_comb begin
    a_x = {{DATA_W{a[DATA_W-1]}}, a};
    b_x = {{DATA_W{b[DATA_W-1]}}, b};
    case (op)
      OP_MUL:  raw = a_x * b_x;
      OP_SUB:  raw = a_x - b_x;
      OP_ADD:  raw = a_x + b_x;
      default: raw = '0;
    endcase
  end

  // Stage 2 input: floor-shift products, saturate/wrap, then flags on final value
  always_comb begin
    shf = (op_p1 == OP_MUL) ? (raw_p1 >>> FRAC_W) : raw_p1;
    sw  = sat_wrap(shf, sat_p1);
    res = '0;
    v   = 1'b0;
    s   = 1'b0;
    case (op_p1)
      OP_MUL, OP_SUB, OP_ADD: begin
        res = sw[DATA_W-1:0];
        v   = sw[DATA_W+1];
        s   = sw[DATA_W];
      end
      OP_SET:  res = c_p1;
      default: res = '0;
    endcase
    flg         = '0;
    flg[FLAG_N] = res[DATA_W-1];
    flg[FLAG_Z] = (res == '0);
    flg[FLAG_V] = v;
    flg[FLAG_S] = s;
  end

endmodule

// File: rtl/alu_vec_pipe.sv
// Two-stage vector ALU with valid/ready handshakes on both sides.
// Stage 1 holds raw double-width lane results plus the captured controls;
// stage 2 holds the final lane values and flags presented downstream.
module alu_vec_pipe
  import alu_vec_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] a,
  input  logic [LANES*DATA_W-1:0] b,
  input  logic [DATA_W-1:0]       c,
  input  logic [2:0]              opcode,
  input  logic                    flag_scalar,
  input  logic                    sat_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] result,
  output logic [LANES*4-1:0]      flags
);

  localparam int XW = 2 * DATA_W;

  logic vld_p1_d, vld_p1_q;
  logic vld_p2_d, vld_p2_q;
  logic s2_ready;
  logic acc;
  logic ld_p2;

  logic signed [XW-1:0] raw_p1_d [LANES];
  logic signed [XW-1:0] raw_p1_q [LANES];
  logic [2:0]           op_p1_d, op_p1_q;
  logic                 sat_p1_d, sat_p1_q;
  logic [DATA_W-1:0]    c_p1_d, c_p1_q;

  logic [LANES*DATA_W-1:0] result_d, result_q;
  logic [LANES*4-1:0]      flags_d, flags_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W-1:0] b_sel;
    assign b_sel = flag_scalar ? b[DATA_W-1:0] : b[i*DATA_W +: DATA_W];

    alu_lane #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_lane (
      .a      (a[i*DATA_W +: DATA_W]),
      .b      (b_sel),
      .op     (opcode),
      .raw    (raw_p1_d[i]),
      .raw_p1 (raw_p1_q[i]),
      .op_p1  (op_p1_q),
      .sat_p1 (sat_p1_q),
      .c_p1   (c_p1_q),
      .res    (result_d[i*DATA_W +: DATA_W]),
      .flg    (flags_d[i*4 +: 4])
    );
  end

  // Handshake: a stage advances whenever the stage after it can take data
  always_comb begin
    s2_ready = !vld_p2_q || out_ready;
    in_ready = !vld_p1_q || s2_ready;
    acc      = in_valid && in_ready;
    ld_p2    = s2_ready && vld_p1_q;
    vld_p1_d = in_ready ? in_valid : vld_p1_q;
    vld_p2_d = s2_ready ? vld_p1_q : vld_p2_q;
    op_p1_d  = opcode;
    sat_p1_d = sat_en;
    c_p1_d   = c;
  end

  // Stage 1 data: captured only on accept, so controls ride with operands
  always_ff @(posedge clk) begin
    if (acc) begin
      raw_p1_q <= raw_p1_d;
      op_p1_q  <= op_p1_d;
      sat_p1_q <= sat_p1_d;
      c_p1_q   <= c_p1_d;
    end
  end

  // Stage valids and stage 2 outputs; reset flushes anything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      if (ld_p2) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: doc/alu_vec_pipe.md
ALU_VEC_PIPE -- requirements
Module: alu_vec_pipe

Interface
REQ-001 SHALL have parameter LANES, default 16, meaning number of vector lanes.
REQ-002 SHALL have parameter DATA_W, default 16, meaning lane width in bits, two's-complement fixed point.
REQ-003 SHALL have parameter FRAC_W, default 8, meaning fractional bits per lane (Q(DATA_W-FRAC_W).FRAC_W).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  upstream operation valid.
REQ-007 SHALL have port in_ready  output  1  block accepts an operation this cycle.
REQ-008 SHALL have ports a, b  input  LANES*DATA_W  operand vectors; lane i occupies bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port c  input  DATA_W  scalar immediate for SET.
REQ-010 SHALL have port opcode  input  3  000 MUL, 001 SUB, 010 ADD, 111 SET, others reserved.
REQ-011 SHALL have port flag_scalar  input  1  1 = b lane 0 broadcast to all lanes.
REQ-012 SHALL have port sat_en  input  1  1 = saturate on overflow, 0 = wrap.
REQ-013 SHALL have port out_valid  output  1  result/flags valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts result.
REQ-015 SHALL have port result  output  LANES*DATA_W  result vector, same lane layout as a.
REQ-016 SHALL have port flags  output  LANES*4  lane i bits [4i+3:4i] = {N, Z, V, S}.

Function
REQ-017 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-018 SHALL implement a 2-stage pipeline: stage 1 registers raw full-width sums/products, stage 2 registers shifted/saturated result and flags; latency 2 cycles accept-to-out_valid with no stall.
REQ-019 SHALL drive in_ready = !s1_valid || s2_ready, where s2_ready = !out_valid || out_ready (combinational back-pressure, no bubbles at full throughput, one operation per cycle).
REQ-020 SHALL hold result, flags and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL, when flag_scalar=1, use b lane 0 as the b operand of every lane; otherwise lane-wise b.
REQ-022 SHALL compute ADD/SUB in DATA_W+1 bits; MUL as 2*DATA_W signed product arithmetically shifted right FRAC_W (truncation toward negative infinity).
REQ-023 SHALL set V when the exact result is outside [-2^(DATA_W-1), 2^(DATA_W-1)-1]; with sat_en=1 clamp to that bound and set S; with sat_en=0 keep low DATA_W bits and clear S.
REQ-024 SHALL, for SET, drive every lane to c with V=S=0, independent of a, b, flag_scalar.
REQ-025 SHALL, for reserved opcodes, drive all lanes to 0 with Z=1, N=V=S=0, and still complete the handshake.
REQ-026 SHALL set N = final lane MSB and Z = (final lane == 0), evaluated after saturation/wrap.
REQ-027 SHALL capture opcode, flag_scalar, sat_en with the operands at accept; later changes SHALL not affect in-flight operations.

Reset
REQ-028 SHALL, while rst=1, clear all stage valids, out_valid=0, result=0, flags=0; in_ready SHALL read 1 during and after reset.
REQ-029 SHALL discard in-flight operations when rst asserts mid-pipeline; no stale output after rst deasserts.

Structure
REQ-030 SHALL place opcode enum (OP_MUL, OP_SUB, OP_ADD, OP_SET), flag bit indices and default LANES/DATA_W/FRAC_W in shared package alu_vec_pkg.
REQ-031 SHALL instantiate one per-lane sub-module alu_lane (arithmetic, saturation, flags) LANES times via generate; pipeline control stays in alu_vec_pipe.

Verification
REQ-032 MUL vector: lane0 a=0x0180 (1.5), b=0xFE40 (-1.75) -> 0xFD60, N=1,Z=0,V=0,S=0, out_valid exactly 2 cycles after accept.
REQ-033 MUL scalar: flag_scalar=1, b lane0=0xFE80 (-1.5), a lane0=0x0140, lane1=0x0180 -> lanes 0xFE20, 0xFDC0.
REQ-034 ADD overflow: a=0x7F00, b=0x0200, sat_en=1 -> 0x7FFF, V=1,S=1; sat_en=0 -> 0x8100, V=1,S=0,N=1.
REQ-035 SET: c=0xFF00 -> all lanes 0xFF00, flags per lane 4'b1000; reserved opcode 3'b100 -> all lanes 0, flags 4'b0100.
REQ-036 Back-pressure: out_ready=0, three back-to-back in_valid -> two accepted, in_ready=0 on third; out_ready=1 -> results emerge in order, no loss or duplication.
REQ-037 Reset mid-flight: rst pulsed with two operations in pipeline -> out_valid=0 after reset, no stale result emitted.
